adder_subtractor_32bit: RTL and testbench
=========================================

// Module: adder_subtractor_32bit
// PURPOSE
//  - Registered 32-bit two's-complement adder/subtractor for the RISC-V datapath ALU.
//  - op=0: result = reg1 + reg2.
//  - op=1: result = reg1 - reg2.
//  - Carry out exported as cout; result and cout both updated on clk rising edge.
// PARAMETERS
//  - WIDTH  32  operand/result width; all behaviour below holds for any WIDTH>=1
// PORTS
//  - clk     in   1      single clock; all state updates on rising edge
//  - rst     in   1      reset: synchronous, active-high
//  - reg1    in   WIDTH  operand A (minuend for subtract)
//  - reg2    in   WIDTH  operand B (subtrahend for subtract)
//  - op      in   1      0 = add, 1 = subtract
//  - result  out  WIDTH  registered sum/difference
//  - cout    out  1      registered carry out of MSB
// BEHAVIOUR
//  - Arithmetic (combinational core): b_eff = reg2 XOR {WIDTH{op}}, cin = op.
//    {c, s} = reg1 + b_eff + cin, computed in WIDTH+1 bits.
//  - Add: cout = unsigned carry.
//  - Subtract: cout = 1 means no borrow (reg1 >= reg2 unsigned); cout = 0 means borrow.
//  - Latency: exactly 1 cycle. Operands/op sampled at edge N; result/cout valid after edge N.
//  - New operation accepted every cycle; no handshake, no stall.
//  - Reset: rst=1 at a rising edge forces result=0 and cout=0, overriding any operation.
//    Operands presented in that cycle are discarded.
//  - First valid output appears one edge after rst deasserts with operands applied.
//  - Wrap-around: modulo 2^WIDTH, no saturation, no overflow flag.
//    - 0xFFFFFFFF+1 -> 0, cout=1.
//    - 0-1 -> 0xFFFFFFFF, cout=0.
//  - Signed interpretation is the consumer's concern; bit pattern is identical.
//  - op toggling between cycles: each cycle's op applies only to that cycle's operands.
//  - Outputs are X-free after the first reset edge.
// STRUCTURE
//  - Shared package alu_pkg:
//    - localparam logic OP_ADD = 1'b0, OP_SUB = 1'b1.
//    - localparam int XLEN = 32 (default for WIDTH).
//  - Sub-module full_adder_1bit (a, b, cin -> s, cout).
//    - Instantiated WIDTH times via generate as an explicit ripple-carry chain.
//    - Bit 0 cin = op; final carry feeds the cout register.
//  - Top level holds:
//    - b-inversion XOR row.
//    - Generate chain.
//    - Output register with synchronous reset.
// TESTING
//  - rst=1 one edge, reg1=30, reg2=10, op=0 -> result=0, cout=0.
//    Deassert rst: next edge result=40, cout=0.
//  - Back-to-back, one edge apart:
//    - (10,20,add) -> 30, cout=0
//    - (5,10,sub) -> 0xFFFFFFFB, cout=0
//    - (30,10,add) -> 40
//    - (30,10,sub) -> 20, cout=1
//  - Wrap:
//    - (0xFFFFFFFF,1,add) -> 0, cout=1
//    - (0,1,sub) -> 0xFFFFFFFF, cout=0
//    - (7,7,sub) -> 0, cout=1
//  - Signed boundary: (0x7FFFFFFF,1,add) -> 0x80000000, cout=0.
//  - Reset mid-stream: assert rst while (100,1,sub) applied -> result=0, cout=0 at that edge.
//    Next edge after deassert -> 99, cout=1.
//  - Random: 10k random reg1/reg2/op vs reference model {cout,result} = reg1 + (op ? ~reg2+1 : reg2).
//    Check result and cout each cycle with 1-cycle delay.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and default datapath width.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int XLEN = 32;

endpackage

// File: rtl/full_adder_1bit.sv
// Single-bit full adder; one stage of the ripple-carry chain.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_subtractor_32bit.sv
// Registered two's-complement adder/subtractor built from an explicit ripple-carry chain.
module adder_subtractor_32bit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  input  logic             op,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;

  logic [WIDTH-1:0] result_d, result_q;
  logic             cout_d, cout_q;

  // Subtract is reg1 + ~reg2 + 1: invert B and inject the +1 as the chain's carry-in.
  assign b_eff    = reg2 ^ {WIDTH{op == OP_SUB}};
  assign carry[0] = (op == OP_SUB);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder_1bit u_fa (
      .a    (reg1[i]),
      .b    (b_eff[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  always_comb begin
    result_d = sum;
    cout_d   = carry[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_adder_subtractor_32bit.sv
// Self-checking bench: directed literal vectors plus randomized stimulus against a behavioural model.
module tb_adder_subtractor_32bit;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] reg1;
  logic [W-1:0] reg2;
  logic         op;
  logic [W-1:0] dut_result;
  logic         dut_cout;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state: what the outputs must show after the most recent edge.
  logic [W-1:0] m_res;
  logic         m_cout;
  bit           m_valid = 0;

  adder_subtractor_32bit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .reg1   (reg1),
    .reg2   (reg2),
    .op     (op),
    .result (dut_result),
    .cout   (dut_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // Reference model: add is plain unsigned addition; subtract wraps and reports no-borrow.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_res  = '0;
        m_cout = 1'b0;
      end else if (op) begin
        m_res  = reg1 - reg2;
        m_cout = (reg1 >= reg2);
      end else begin
        {m_cout, m_res} = {1'b0, reg1} + {1'b0, reg2};
      end
      m_valid = 1;
    end
  end

  // Compare process: checks every cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        checks++;
        if ($isunknown({dut_cout, dut_result}) || dut_result !== m_res || dut_cout !== m_cout) begin
          failures++;
          $display("FAIL model_cmp t=%0t: got result=%h cout=%b, expected result=%h cout=%b",
                   $time, dut_result, dut_cout, m_res, m_cout);
        end
      end
    end
  end

  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                       input logic r);
    reg1 = a;
    reg2 = b;
    op   = o;
    rst  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [W-1:0] exp_res, input logic exp_cout);
    checks++;
    if (dut_result !== exp_res || dut_cout !== exp_cout) begin
      failures++;
      $display("FAIL %s: got result=%h cout=%b, expected result=%h cout=%b",
               name, dut_result, dut_cout, exp_res, exp_cout);
    end
  endtask

  initial begin
    rst  = 1'b1;
    reg1 = '0;
    reg2 = '0;
    op   = 1'b0;

    // Reset overrides the operation presented in the same cycle.
    apply(32'd30, 32'd10, 1'b0, 1'b1);
    check_lit("reset_state", 32'd0, 1'b0);
    apply(32'd30, 32'd10, 1'b0, 1'b0);
    check_lit("first_after_reset", 32'd40, 1'b0);

    // Back-to-back with op toggling.
    apply(32'd10, 32'd20, 1'b0, 1'b0);
    check_lit("add_10_20", 32'd30, 1'b0);
    apply(32'd5, 32'd10, 1'b1, 1'b0);
    check_lit("sub_5_10", 32'hFFFF_FFFB, 1'b0);
    apply(32'd30, 32'd10, 1'b0, 1'b0);
    check_lit("add_30_10", 32'd40, 1'b0);
    apply(32'd30, 32'd10, 1'b1, 1'b0);
    check_lit("sub_30_10", 32'd20, 1'b1);

    // Wrap-around and boundaries.
    apply(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    check_lit("wrap_add", 32'd0, 1'b1);
    apply(32'd0, 32'd1, 1'b1, 1'b0);
    check_lit("wrap_sub", 32'hFFFF_FFFF, 1'b0);
    apply(32'd7, 32'd7, 1'b1, 1'b0);
    check_lit("sub_equal", 32'd0, 1'b1);
    apply(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    check_lit("signed_boundary", 32'h8000_0000, 1'b0);
    apply(32'd5, 32'd0, 1'b1, 1'b0);
    check_lit("sub_zero", 32'd5, 1'b1);

    // Reset mid-stream.
    apply(32'd100, 32'd1, 1'b1, 1'b1);
    check_lit("reset_midstream", 32'd0, 1'b0);
    apply(32'd100, 32'd1, 1'b1, 1'b0);
    check_lit("after_midstream_reset", 32'd99, 1'b1);

    // Randomized stimulus, with occasional edge-value operands and sporadic resets.
    for (int i = 0; i < 10000; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: a = '1;
        1: b = '1;
        2: b = a;
        3: a = '0;
        default: ;
      endcase
      apply(a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
